panda_mem_arbiter: RTL and testbench

PANDA_MEM_ARBITER -- requirements
Module: panda_mem_arbiter

---
 rtl/panda_pkg.sv | 10 +
 rtl/panda_arb_2way.sv | 34 +++
 rtl/panda_mem_arbiter.sv | 100 ++++++++++
 tb/tb_panda_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types for the panda memory arbiter: owner encoding used for
// response routing and round-robin history.
package panda_pkg;

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

endpackage

// File: rtl/panda_arb_2way.sv
// Two-requester grant logic, one-hot output (bit 0 = instr, bit 1 = data).
// Round robin on conflict when PANDA_ARB_RR_EN is defined, else data wins.
module panda_arb_2way
  import panda_pkg::*;
(
  input  logic       req_instr,
  input  logic       req_data,
`ifdef PANDA_ARB_RR_EN
  input  owner_e     last_winner,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_instr && req_data) begin
`ifdef PANDA_ARB_RR_EN
      // Hand the conflict to whichever port did not win most recently.
      if (last_winner == OwnerData) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
`else
      gnt = 2'b10;
`endif
    end else if (req_instr) begin
      gnt = 2'b01;
    end else if (req_data) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/panda_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port RAM. Optional round-robin conflict policy: PANDA_ARB_RR_EN.
module panda_mem_arbiter
  import panda_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   instr_req_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,

  input  logic                   data_req_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth/8-1:0] data_we_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,

  output logic                   mem_ce_o,
  output logic [DataWidth/8-1:0] mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,

  output logic [31:0]            conflict_cnt_o
);

  localparam int StrbWidth = DataWidth / 8;

  logic [1:0]  arb_gnt;
  logic        instr_gnt;
  logic        data_gnt;
  logic        resp_valid;
  owner_e      resp_owner;
  logic [31:0] conflict_cnt;
`ifdef PANDA_ARB_RR_EN
  owner_e      last_winner;
`endif

  panda_arb_2way u_arb (
    .req_instr   (instr_req_i),
    .req_data    (data_req_i),
`ifdef PANDA_ARB_RR_EN
    .last_winner (last_winner),
`endif
    .gnt         (arb_gnt)
  );

  // Reset masks grants so nothing reaches the RAM while it is held.
  assign instr_gnt = arb_gnt[0] & ~rst_i;
  assign data_gnt  = arb_gnt[1] & ~rst_i;

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  assign mem_ce_o    = instr_gnt | data_gnt;
  assign mem_addr_o  = data_gnt ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_we_o    = data_gnt ? data_we_i : {StrbWidth{1'b0}};

  // Reset in the response cycle drops the pending response outright.
  assign instr_rvalid_o = resp_valid & (resp_owner == OwnerInstr) & ~rst_i;
  assign data_rvalid_o  = resp_valid & (resp_owner == OwnerData) & ~rst_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign conflict_cnt_o = conflict_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid   <= 1'b0;
      resp_owner   <= OwnerInstr;
      conflict_cnt <= 32'd0;
    end else begin
      resp_valid <= instr_gnt | data_gnt;
      resp_owner <= data_gnt ? OwnerData : OwnerInstr;
      if (instr_req_i && data_req_i) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

`ifdef PANDA_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner <= OwnerInstr;
    end else if (instr_gnt || data_gnt) begin
      last_winner <= data_gnt ? OwnerData : OwnerInstr;
    end
  end
`endif

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Directed scoreboard bench for panda_mem_arbiter with a behavioural RAM;
// follows the DUT's policy when PANDA_ARB_RR_EN is defined.
module tb_panda_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_ce_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] conflict_cnt_o;

  typedef struct {
    bit          is_data;
    bit          chk_data;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_cnt = 0;
  bit          model_last = 1'b0;

  always #5 clk_i = ~clk_i;

  panda_mem_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_ce_o       (mem_ce_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .conflict_cnt_o (conflict_cnt_o)
  );

  // Single-port RAM, one-cycle read latency, byte-enabled writes.
  always @(posedge clk_i) begin
    if (mem_ce_o) begin
      if (|mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= ram[mem_addr_o[7:2]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check just after, then update the model.
  task automatic applyStimulus(input bit rst, input bit ir, input logic [31:0] ia,
                               input bit dr, input logic [31:0] da,
                               input logic [3:0] we, input logic [31:0] wd);
    bit    exp_gi;
    bit    exp_gd;
    resp_t r;
    @(negedge clk_i);
    rst_i        = rst;
    instr_req_i  = ir;
    instr_addr_i = ia;
    data_req_i   = dr;
    data_addr_i  = da;
    data_we_i    = we;
    data_wdata_i = wd;
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (rst) begin
        checkOutput("rvalid_instr_dropped", {31'd0, instr_rvalid_o}, 32'd0);
        checkOutput("rvalid_data_dropped", {31'd0, data_rvalid_o}, 32'd0);
      end else begin
        checkOutput("instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, !r.is_data});
        checkOutput("data_rvalid", {31'd0, data_rvalid_o}, {31'd0, r.is_data});
        if (r.chk_data) begin
          if (r.is_data) checkOutput("data_rdata", data_rdata_o, r.data);
          else           checkOutput("instr_rdata", instr_rdata_o, r.data);
        end
      end
    end else begin
      checkOutput("instr_rvalid_idle", {31'd0, instr_rvalid_o}, 32'd0);
      checkOutput("data_rvalid_idle", {31'd0, data_rvalid_o}, 32'd0);
    end

    exp_gi = 1'b0;
    exp_gd = 1'b0;
    if (!rst) begin
      if (ir && dr) begin
`ifdef PANDA_ARB_RR_EN
        exp_gd = !model_last;
        exp_gi = model_last;
`else
        exp_gd = 1'b1;
`endif
      end else begin
        exp_gi = ir;
        exp_gd = dr;
      end
    end
    checkOutput("instr_gnt", {31'd0, instr_gnt_o}, {31'd0, exp_gi});
    checkOutput("data_gnt", {31'd0, data_gnt_o}, {31'd0, exp_gd});
    checkOutput("mem_ce", {31'd0, mem_ce_o}, {31'd0, exp_gi | exp_gd});
    checkOutput("mem_we", {28'd0, mem_we_o}, exp_gd ? {28'd0, we} : 32'd0);
    if (exp_gi) checkOutput("mem_addr_instr", mem_addr_o, ia);
    if (exp_gd) begin
      checkOutput("mem_addr_data", mem_addr_o, da);
      checkOutput("mem_wdata", mem_wdata_o, wd);
    end
    checkOutput("conflict_cnt", conflict_cnt_o, model_cnt);

    if (rst) begin
      model_cnt  = 32'd0;
      model_last = 1'b0;
      sb.delete();
    end else begin
      if (ir && dr) model_cnt = model_cnt + 32'd1;
      if (exp_gi || exp_gd) begin
        model_last = exp_gd;
        r.is_data  = exp_gd;
        r.chk_data = !(exp_gd && (we != 4'h0));
        r.data     = exp_gd ? ref_mem[da[7:2]] : ref_mem[ia[7:2]];
        sb.push_back(r);
        if (exp_gd) begin
          for (int b = 0; b < 4; b++) begin
            if (we[b]) ref_mem[da[7:2]][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    rst_i = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = '0; data_wdata_i = '0;

    // Reset held with both requests high: no grants may appear.
    applyStimulus(1, 1, 32'h10, 1, 32'h8, 4'hF, 32'h0);
    applyStimulus(1, 1, 32'h10, 1, 32'h8, 4'hF, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

    // Preload word 4, then fetch it through the instruction port.
    applyStimulus(0, 0, 32'h0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 32'h10, 0, 32'h0, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

    // Back-to-back store/load/partial store/load on the data port.
    applyStimulus(0, 0, 32'h0, 1, 32'h8, 4'hF, 32'h1234_5678);
    applyStimulus(0, 0, 32'h0, 1, 32'h8, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 32'h8, 4'h3, 32'hAAAA_BBBB);
    applyStimulus(0, 0, 32'h0, 1, 32'h8, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

    // Fresh reset, then four conflict cycles.
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 32'h10, 1, 32'h8, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    checkOutput("conflict_cnt_after4", conflict_cnt_o, 32'd4);

    // Grant followed immediately by reset: response dropped, counter cleared.
    applyStimulus(0, 1, 32'h10, 0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1, 32'h10, 1, 32'h8, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

    // Counter wrap from all-ones.
    @(negedge clk_i);
    force dut.conflict_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.conflict_cnt;
    model_cnt = 32'hFFFF_FFFF;
    applyStimulus(0, 1, 32'h10, 1, 32'h8, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    checkOutput("conflict_cnt_wrap", conflict_cnt_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
